// File: rtl/ofdm_tx_pkg.sv
// rtl/ofdm_tx_pkg.sv - shared defaults, read FSM encoding and address-width helper for the CP inserter
package ofdm_tx_pkg;

    localparam int N_FFT_DEF  = 64;
    localparam int CP_LEN_DEF = 16;
    localparam int DW_DEF     = 16;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_CP   = 2'd1,
        RD_BODY = 2'd2
    } rd_state_e;

    // Sample-index width inside one bank; the bank bit is appended on top of this.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ofdm_tx_cp_insert_ram.sv
// rtl/ofdm_tx_cp_insert_ram.sv - two-bank symbol RAM, one write port, one registered read port
module tx_sym_bank_ram
    import ofdm_tx_pkg::*;
#(
    parameter int AW    = addr_width(N_FFT_DEF) + 1,
    parameter int WIDTH = 2 * DW_DEF
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [0:(1<<AW)-1];
    logic [WIDTH-1:0] rdata_q;

    // Sample storage, addressed as {bank, index}.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; a same-address write is forwarded so an early read of the newest sample is safe.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ofdm_tx_cp_insert.sv
// rtl/ofdm_tx_cp_insert.sv - ping-pong buffered cyclic-prefix inserter between IFFT and DAC path
module ofdm_tx_cp_insert
    import ofdm_tx_pkg::*;
#(
    parameter int N_FFT  = N_FFT_DEF,
    parameter int CP_LEN = CP_LEN_DEF,
    parameter int DW     = DW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [2*DW-1:0] s_data,
    input  logic            s_last,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [2*DW-1:0] m_data,
    output logic            m_sop,
    output logic            m_eop,
    output logic            sym_err
);

    localparam int AW = addr_width(N_FFT);
    localparam logic [AW-1:0] ONE     = AW'(1);
    localparam logic [AW-1:0] LAST    = AW'(N_FFT - 1);
    localparam logic [AW-1:0] CP_LAST = AW'(CP_LEN - 1);
    localparam logic [AW-1:0] CP_BASE = AW'(N_FFT - CP_LEN);

    logic [1:0]      full_q, full_d, wr_set, rd_clr;
    logic            wbank_q, wbank_d, rbank_q, rbank_d;
    logic [AW-1:0]   wcnt_q, wcnt_d, rcnt_q, rcnt_d, raddr_lo;
    logic            sym_err_q, sym_err_d;
    rd_state_e       state_q, state_d;
    logic            accept, wr_done_now, rd_active, rd_fire, can_issue, pop, out_free;
    logic            issue_sop, issue_eop;
    logic [1:0]      occ;
    logic            ram_vld_q, ram_vld_d, ram_sop_q, ram_sop_d, ram_eop_q, ram_eop_d;
    logic            skid_v_q, skid_v_d, skid_sop_q, skid_sop_d, skid_eop_q, skid_eop_d;
    logic [2*DW-1:0] skid_data_q, skid_data_d, ram_rdata;
    logic            m_valid_q, m_valid_d, m_sop_q, m_sop_d, m_eop_q, m_eop_d;
    logic [2*DW-1:0] m_data_q, m_data_d;

    assign s_ready = ~full_q[wbank_q];
    assign accept  = s_valid & s_ready;

    // Write side: fill the current bank, close it on sample N_FFT-1, drop it on an early s_last.
    always_comb begin
        wbank_d   = wbank_q;
        wcnt_d    = wcnt_q;
        sym_err_d = 1'b0;
        wr_set    = 2'b00;
        if (accept) begin
            if (wcnt_q == LAST) begin
                wr_set[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
                wcnt_d          = '0;
                sym_err_d       = ~s_last;
            end else if (s_last) begin
                wcnt_d    = '0;
                sym_err_d = 1'b1;
            end else begin
                wcnt_d = wcnt_q + ONE;
            end
        end
    end

    // Bank completing this cycle into the idle read bank may be read at once (its CP region is already written).
    assign wr_done_now = accept && (wcnt_q == LAST) && (wbank_q == rbank_q) && (state_q == RD_IDLE);
    assign rd_active   = (state_q != RD_IDLE) || full_q[rbank_q] || wr_done_now;

    // Output slots (output reg + skid) minus what leaves this cycle must leave room for the read in flight.
    assign pop       = m_valid_q & m_ready;
    assign out_free  = ~m_valid_q | m_ready;
    assign occ       = {1'b0, m_valid_q} + {1'b0, skid_v_q} + {1'b0, ram_vld_q};
    assign can_issue = (occ - {1'b0, pop}) < 2'd2;
    assign rd_fire   = rd_active & can_issue;

    // Read sequencer: CP indices N_FFT-CP_LEN..N_FFT-1, then body 0..N_FFT-1, release bank on the last read.
    always_comb begin
        state_d   = state_q;
        rbank_d   = rbank_q;
        rcnt_d    = rcnt_q;
        rd_clr    = 2'b00;
        issue_sop = 1'b0;
        issue_eop = 1'b0;
        raddr_lo  = (state_q == RD_BODY) ? rcnt_q : (CP_BASE + rcnt_q);
        if (rd_fire) begin
            if (state_q != RD_BODY) begin
                issue_sop = (rcnt_q == '0);
                if (rcnt_q == CP_LAST) begin
                    state_d = RD_BODY;
                    rcnt_d  = '0;
                end else begin
                    state_d = RD_CP;
                    rcnt_d  = rcnt_q + ONE;
                end
            end else if (rcnt_q == LAST) begin
                issue_eop       = 1'b1;
                rd_clr[rbank_q] = 1'b1;
                rbank_d         = ~rbank_q;
                rcnt_d          = '0;
                state_d         = full_q[~rbank_q] ? RD_CP : RD_IDLE;
            end else begin
                rcnt_d = rcnt_q + ONE;
            end
        end
    end

    assign full_d = (full_q | wr_set) & ~rd_clr;

    // Output stage: oldest data first (skid before fresh RAM data); stalled data parks in the skid.
    always_comb begin
        ram_vld_d   = rd_fire;
        ram_sop_d   = issue_sop;
        ram_eop_d   = issue_eop;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        skid_sop_d  = skid_sop_q;
        skid_eop_d  = skid_eop_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_sop_d     = m_sop_q;
        m_eop_d     = m_eop_q;
        if (out_free) begin
            if (skid_v_q) begin
                m_valid_d   = 1'b1;
                m_data_d    = skid_data_q;
                m_sop_d     = skid_sop_q;
                m_eop_d     = skid_eop_q;
                skid_v_d    = ram_vld_q;
                skid_data_d = ram_rdata;
                skid_sop_d  = ram_sop_q;
                skid_eop_d  = ram_eop_q;
            end else if (ram_vld_q) begin
                m_valid_d = 1'b1;
                m_data_d  = ram_rdata;
                m_sop_d   = ram_sop_q;
                m_eop_d   = ram_eop_q;
            end else begin
                m_valid_d = 1'b0;
                m_sop_d   = 1'b0;
                m_eop_d   = 1'b0;
            end
        end else if (ram_vld_q) begin
            skid_v_d    = 1'b1;
            skid_data_d = ram_rdata;
            skid_sop_d  = ram_sop_q;
            skid_eop_d  = ram_eop_q;
        end
    end

    // State registers; reset discards everything buffered or in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q      <= 2'b00;
            wbank_q     <= 1'b0;
            wcnt_q      <= '0;
            sym_err_q   <= 1'b0;
            state_q     <= RD_IDLE;
            rbank_q     <= 1'b0;
            rcnt_q      <= '0;
            ram_vld_q   <= 1'b0;
            ram_sop_q   <= 1'b0;
            ram_eop_q   <= 1'b0;
            skid_v_q    <= 1'b0;
            skid_data_q <= '0;
            skid_sop_q  <= 1'b0;
            skid_eop_q  <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_sop_q     <= 1'b0;
            m_eop_q     <= 1'b0;
        end else begin
            full_q      <= full_d;
            wbank_q     <= wbank_d;
            wcnt_q      <= wcnt_d;
            sym_err_q   <= sym_err_d;
            state_q     <= state_d;
            rbank_q     <= rbank_d;
            rcnt_q      <= rcnt_d;
            ram_vld_q   <= ram_vld_d;
            ram_sop_q   <= ram_sop_d;
            ram_eop_q   <= ram_eop_d;
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
            skid_sop_q  <= skid_sop_d;
            skid_eop_q  <= skid_eop_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_sop_q     <= m_sop_d;
            m_eop_q     <= m_eop_d;
        end
    end

    tx_sym_bank_ram #(
        .AW    (AW + 1),
        .WIDTH (2 * DW)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr ({wbank_q, wcnt_q}),
        .wdata (s_data),
        .re    (rd_fire),
        .raddr ({rbank_q, raddr_lo}),
        .rdata (ram_rdata)
    );

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_sop   = m_sop_q;
    assign m_eop   = m_eop_q;
    assign sym_err = sym_err_q;

endmodule
